leaf_out_arb: RTL
=================

# leaf_out_arb

Round-robin arbiter that lets up to NUM_REQ user output streams share the single user-to-interface output port of a leaf's leaf_interface. It sits between several accelerator output streams (each with 32-bit data and a valid/ack handshake) and the leaf_interface `din_leaf_user2interface`/`vld_user2interface`/`ack_interface2user` inputs. Each grant is held for a burst of at most MAX_BURST words, and the output is presented through a one-entry register slice.

## Interface
Parameters:
- PAYLOAD_BITS, 32, data width per word (matches leaf_interface PAYLOAD_BITS)
- NUM_REQ, 4, number of requester streams (2..16)
- MAX_BURST, 16, maximum words transferred per grant (>=1)

Ports:
- clk  input  1  single clock
- reset  input  1  synchronous, active-high reset
- din_user2arb  input  NUM_REQ*PAYLOAD_BITS  requester data; requester i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS]
- vld_user2arb  input  NUM_REQ  per-requester valid
- ack_arb2user  output  NUM_REQ  per-requester ack; the word transfers in any cycle where valid and ack are both high
- dout_arb2interface  output  PAYLOAD_BITS  data to leaf_interface (registered)
- vld_arb2interface  output  1  valid to leaf_interface (registered)
- ack_interface2arb  input  1  ack from leaf_interface
- grant_idx  output  clog2(NUM_REQ)  index of the current or last granted requester
- busy  output  1  high while state is GRANT

## Operation
State machine:
- **IDLE**
  - If any `vld_user2arb` bit is high, pick the first requester with valid high, searching from `rr_ptr` upward with wrap-around.
  - Load that index into `grant_idx`, clear `beat_cnt`, and go to GRANT.
  - If no valid is high, stay in IDLE.
- **GRANT**
  - Let g = `grant_idx`. Define xfer = `vld_user2arb[g]` & (!`vld_arb2interface` | `ack_interface2arb`).
  - Drive `ack_arb2user[g]` = xfer. All other ack bits are 0. Ack is combinational.
  - On xfer:
    - load the requester's word into `dout_arb2interface`
    - set `vld_arb2interface`
    - increment `beat_cnt`
  - Release the grant, go to IDLE and set `rr_ptr` = (g+1) mod NUM_REQ when either:
    - xfer occurs with `beat_cnt` == MAX_BURST-1, or
    - `vld_user2arb[g]` is low in any GRANT cycle.
  - Otherwise stay in GRANT.

Output register:
- `vld_arb2interface` clears when `ack_interface2arb` is high and no new xfer occurs that cycle.
- `dout_arb2interface` holds its value while valid is high and ack is low.

Width rules:
- `beat_cnt` is clog2(MAX_BURST+1) bits.
- `rr_ptr` wraps from NUM_REQ-1 to 0; no out-of-range index is ever produced.

Reset values (all outputs and internal state):
- state IDLE
- `rr_ptr` 0, `beat_cnt` 0, `grant_idx` 0
- `vld_arb2interface` 0, `dout_arb2interface` 0
- `ack_arb2user` all 0, `busy` 0

## Timing
- Arbitration latency: a requester valid in IDLE at cycle t is granted at t+1. The first ack is no earlier than t+1, and its data appears on the output at t+2.
- Throughput: one word per cycle while granted and the downstream acks every cycle.
- Grant switch: one dead cycle in IDLE between consecutive grants.
- Downstream stall: when `vld_arb2interface` is high and ack is low, the requester ack stays 0 and no data is lost or duplicated.
- Requester drops valid mid-burst: the grant is released that same cycle, with no ack. Re-arbitration happens in the next IDLE cycle, and that requester is then lowest priority.
- Requester asserts valid while another requester is granted: it is not acked until its own grant.
- MAX_BURST=1: every word is followed by an IDLE cycle, giving strict round robin.
- Reset mid-burst: a word held in the output register is discarded and `vld_arb2interface` is 0 on the next cycle. Requesters must resend.

## Test plan
- **Single requester:** requester 2 valid continuously with data 0x100+n, downstream acks always, MAX_BURST=16.
  - Required: `grant_idx`=2 one cycle after valid.
  - 16 consecutive words 0x100..0x10F on the output, then one IDLE gap, then re-grant to 2.
- **All four requesters valid with MAX_BURST=4, after reset:**
  - Required grant order 0,1,2,3,0.
  - Each burst is exactly 4 words, with a 1-cycle gap between bursts.
- **Backpressure:** hold `ack_interface2arb` low for 5 cycles mid-burst.
  - Required: `dout_arb2interface` stable, `ack_arb2user` 0 during the stall.
  - No lost or duplicated words; the output sequence matches the input sequence.
- **Early release:** requester 1 drops valid after 3 words while requester 3 is waiting.
  - Required: `busy` falls, and requester 3 is granted one cycle later.
  - `rr_ptr`=2, so requester 1 is not re-granted before requester 3.
- **Reset during burst:** assert `reset` with `vld_arb2interface`=1.
  - Required next cycle: `vld_arb2interface`=0, `dout`=0, `grant_idx`=0, `busy`=0, all acks 0.

Source files
------------

// File: rtl/leaf_out_arb.sv
// Round-robin arbiter merging NUM_REQ valid/ack word streams onto one leaf_interface
// user output port, with bounded bursts per grant and a one-entry registered output.
module leaf_out_arb #(
  parameter int PAYLOAD_BITS = 32,
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_user2arb,
  input  logic [NUM_REQ-1:0]              vld_user2arb,
  output logic [NUM_REQ-1:0]              ack_arb2user,
  output logic [PAYLOAD_BITS-1:0]         dout_arb2interface,
  output logic                            vld_arb2interface,
  input  logic                            ack_interface2arb,
  output logic [$clog2(NUM_REQ)-1:0]      grant_idx,
  output logic                            busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CW    = IDX_W + 1;
  localparam int BC_W  = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        pick;
  logic [CW-1:0]           cand;
  logic                    found;
  logic                    any_vld;
  logic [BC_W-1:0]         beat_cnt;
  logic                    vld_g;
  logic [PAYLOAD_BITS-1:0] din_g;
  logic                    xfer;
  logic                    last_beat;
  logic                    release_g;

  // Arbitration: first valid requester at or after rr_ptr, wrapping around
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + CW'(k);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!found && vld_user2arb[cand[IDX_W-1:0]]) begin
        pick  = cand[IDX_W-1:0];
        found = 1'b1;
      end
    end
  end

  assign any_vld   = |vld_user2arb;
  assign vld_g     = vld_user2arb[grant_idx];
  assign din_g     = din_user2arb[int'(grant_idx)*PAYLOAD_BITS +: PAYLOAD_BITS];
  // A word moves when the output slot is empty or being drained this cycle
  assign xfer      = (state == GRANT) && vld_g && (!vld_arb2interface || ack_interface2arb);
  assign last_beat = (beat_cnt == BC_W'(MAX_BURST - 1));
  assign release_g = (state == GRANT) && (!vld_g || (xfer && last_beat));

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_vld)   state_nxt = GRANT;
      GRANT:   if (release_g) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs; ack is suppressed during reset so no word is consumed and then dropped
  always_comb begin
    busy                    = (state == GRANT);
    ack_arb2user            = '0;
    ack_arb2user[grant_idx] = xfer && !reset;
  end

  // Grant bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      grant_idx <= '0;
    end else begin
      if (state == IDLE && any_vld) begin
        grant_idx <= pick;
        beat_cnt  <= '0;
      end
      if (xfer) beat_cnt <= beat_cnt + 1'b1;
      if (release_g)
        rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Output register slice
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_arb2interface  <= 1'b0;
      dout_arb2interface <= '0;
    end else if (xfer) begin
      vld_arb2interface  <= 1'b1;
      dout_arb2interface <= din_g;
    end else if (ack_interface2arb) begin
      vld_arb2interface  <= 1'b0;
    end
  end

endmodule
